// File: rtl/qed_replay_buffer.sv
// QED replay buffer: captures original-mode fetches into a circular buffer and
// replays them in program order while in duplicate mode.
module qed_replay_buffer #(
  parameter int          IW         = 32,
  parameter int          DEPTH      = 16,
  parameter int          CW         = $clog2(DEPTH) + 1,
  parameter logic [IW-1:0] NOP      = 32'h0000_0013,
  parameter bit          FILTER_NOP = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          exec_dup,
  input  logic          stall_IF,
  input  logic          ifu_instr_vld,
  input  logic [IW-1:0] ifu_qed_instruction,
  output logic [IW-1:0] qic_qimux_instruction,
  output logic          vld_out,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          sync_pt,
  output logic          ovf_err,
  output logic          unf_err
);

  localparam int AW = $clog2(DEPTH);
  // Pointer difference that marks a full buffer: only the wrap bit set.
  localparam logic [CW-1:0] PTR_WRAP = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ORIG,
    ST_DUP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic            vld_q, vld_d;
  logic            sync_q, sync_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic [IW-1:0]   mem [DEPTH];

  logic            empty_c;
  logic            full_c;
  logic            is_filtered;
  logic            push_req;
  logic            pop_req;
  logic            mem_we;

  assign empty_c     = (wr_ptr_q == rd_ptr_q);
  assign full_c      = ((wr_ptr_q ^ rd_ptr_q) == PTR_WRAP);
  assign is_filtered = FILTER_NOP && (ifu_qed_instruction == NOP);

  // Push and pop are gated by the registered state, so a mode change takes
  // effect one cycle after exec_dup flips.
  assign push_req = (state_q == ST_ORIG) && !stall_IF && ifu_instr_vld &&
                    !exec_dup && !is_filtered;
  assign pop_req  = (state_q == ST_DUP) && !stall_IF && exec_dup;
  assign mem_we   = ena && push_req && !full_c;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // a value unassigned and infer a latch; blocking '=' is correct in comb logic.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    instr_d  = instr_q;
    vld_d    = vld_q;
    sync_d   = sync_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (!ena) begin
      state_d = ST_IDLE;
    end else if (exec_dup) begin
      state_d = ST_DUP;
    end else begin
      state_d = ST_ORIG;
    end

    if (!ena) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      instr_d  = NOP;
      vld_d    = 1'b0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else if (!stall_IF) begin
      instr_d = NOP;
      vld_d   = 1'b0;

      if (push_req) begin
        if (full_c) begin
          ovf_d = 1'b1;
        end else begin
          wr_ptr_d = wr_ptr_q + CW'(1);
        end
      end

      if (pop_req) begin
        if (empty_c) begin
          unf_d = 1'b1;
        end else begin
          instr_d  = mem[rd_ptr_q[AW-1:0]];
          vld_d    = 1'b1;
          rd_ptr_d = rd_ptr_q + CW'(1);
        end
      end
    end

    // Sync point is built from next-cycle values so it lines up with the
    // registered outputs it describes; a stall freezes it like any output.
    if (!ena || !stall_IF) begin
      sync_d = (state_d == ST_ORIG) && (wr_ptr_d == rd_ptr_d) && !vld_d;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // together from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      instr_q  <= NOP;
      vld_q    <= 1'b0;
      sync_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      instr_q  <= instr_d;
      vld_q    <= vld_d;
      sync_q   <= sync_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, because the pointers (which are reset) guard every read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= ifu_qed_instruction;
    end
  end

  assign qic_qimux_instruction = instr_q;
  assign vld_out               = vld_q;
  assign full                  = full_c;
  assign empty                 = empty_c;
  assign count                 = wr_ptr_q - rd_ptr_q;
  assign sync_pt               = sync_q;
  assign ovf_err               = ovf_q;
  assign unf_err               = unf_q;

endmodule

// File: doc/qed_replay_buffer.md
Name: qed_replay_buffer

Overview:
- Parametrised successor to the QED instruction cache.
- In original mode it captures each fetched original instruction into a circular buffer. In duplicate mode it replays those instructions in program order to the instruction-modify stage.
- Compared with the fixed-size cache it adds configurable width and depth, NOP filtering, occupancy and status flags, sticky error flags and a sync-point indication for consistency checks.
- Sits between the IFU fetch output and the QED decoder/modify path.

Parameters:
- IW, 32: instruction width in bits.
- DEPTH, 16: buffer entries; must be a power of 2 and at least 2.
- CW, $clog2(DEPTH)+1: width of the pointers and the occupancy count.
- NOP, 32'h00000013: canonical NOP encoding (addi x0,x0,0).
- FILTER_NOP, 1: when 1, instructions equal to NOP are not captured.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  QED enable; when 0 the buffer is cleared and idle.
- exec_dup  in  1  1 = duplicate (replay) mode, 0 = original mode.
- stall_IF  in  1  fetch stall; freezes push, pop and outputs.
- ifu_instr_vld  in  1  ifu_qed_instruction is a valid fetch this cycle.
- ifu_qed_instruction  in  IW  instruction from the IFU.
- qic_qimux_instruction  out  IW  replayed instruction to the decoder/modify stage.
- vld_out  out  1  qic_qimux_instruction is a valid replay.
- full  out  1  occupancy == DEPTH.
- empty  out  1  occupancy == 0.
- count  out  CW  current occupancy, 0..DEPTH.
- sync_pt  out  1  all captured instructions have been replayed.
- ovf_err  out  1  sticky: push attempted while full.
- unf_err  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr = rd_ptr = 0, state = IDLE.
  - qic_qimux_instruction = NOP; vld_out, ovf_err, unf_err = 0.
  - count = 0, empty = 1, full = 0, sync_pt = 0.
- States: IDLE, ORIG, DUP.
  - Any state, ena=0: go to IDLE and synchronously clear the pointers, vld_out and both error flags.
  - IDLE, ena=1: go to ORIG if exec_dup=0, DUP if exec_dup=1.
  - ORIG to DUP when exec_dup=1; DUP to ORIG when exec_dup=0. Mode is evaluated every cycle, including stalled cycles.
- Stall (stall_IF=1): no push, no pop, and all outputs hold their previous value.
- Push (state ORIG, stall_IF=0, ifu_instr_vld=1, exec_dup=0):
  - If FILTER_NOP=1 and the instruction equals NOP: no push and no error.
  - Else if full: instruction dropped, ovf_err set.
  - Else: mem[wr_ptr] <= instruction, wr_ptr increments.
- Pop (state DUP, stall_IF=0, exec_dup=1), one per cycle:
  - If not empty: qic_qimux_instruction <= mem[rd_ptr], vld_out <= 1, rd_ptr increments. Latency is 1 cycle from the pop cycle to vld_out.
  - If empty: qic_qimux_instruction <= NOP, vld_out <= 0, unf_err set.
- Any non-stalled cycle without a pop drives qic_qimux_instruction <= NOP and vld_out <= 0.
- Push and pop are mutually exclusive by mode, so no simultaneous-access case exists.
- Pointers are CW bits; index = low log2(DEPTH) bits.
  - full: pointers differ only in the MSB.
  - empty: pointers are equal.
  - count = wr_ptr - rd_ptr, modulo 2^CW.
  - Wrap-around is seamless.
- Leaving DUP with entries remaining keeps those entries; replay resumes at rd_ptr on the next DUP entry.
- sync_pt (registered) = (state == ORIG) && empty && !vld_out.
- ovf_err and unf_err clear only on reset or ena=0.

Test Plan:
- Reset: hold rst=0 -> qic_qimux_instruction=0x00000013, vld_out=0, count=0, empty=1, sync_pt=0. Release rst -> one cycle later sync_pt=1 (ena=1, exec_dup=0).
- ORIG push 0x00500093, 0x00208133, 0x0000A183, then exec_dup=1 -> vld_out=1 on 3 consecutive cycles with the same values in order, one cycle after each pop. Fourth pop -> vld_out=0, unf_err=1.
- DEPTH=16: push 16 non-NOP instructions -> full=1, count=16. 17th push -> dropped, ovf_err=1. Replay all 16 -> order preserved, empty=1.
- Wrap: push 12 / replay 12, then push 10 / replay 10 -> all 10 correct across the index-15 to index-0 wrap, count returns to 0.
- FILTER_NOP=1: push 0x00000013 between two real instructions -> count=2, replay shows only the two real instructions. With FILTER_NOP=0 -> count=3.
- Stall and disable:
  - stall_IF=1 for 3 cycles during replay -> outputs and count frozen, no entry skipped.
  - ena=0 mid-replay with count=5 -> next cycle count=0, vld_out=0, errors cleared.
  - rst=0 asserted mid-cycle -> outputs go to reset values immediately.
